// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache-to-memory arbitration slice.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IRD,
        DRD,
        DWR,
        IFILL,
        DFILL,
        DDONE
    } arb_state_t;

    // Direct-mapped line geometry shared by both caches
    localparam int IDX_MSB = 6;
    localparam int IDX_LSB = 2;
    localparam int TAG_LSB = 7;

    // RV32I NOP, so a timed-out fetch executes harmlessly
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0013;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory acknowledge.
// Asserts expired once TIMEOUT cycles have gone by without one.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired,
    output logic expiring
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != 8'(TIMEOUT))) begin
            count <= count + 8'd1;
        end
    end

    assign expired  = (count == 8'(TIMEOUT));
    // Lets the request drop one cycle before the timeout cycle itself
    assign expiring = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache refills, dcache refills and write-through stores.
// Data requests win over fetches, and a bounded wait turns a dead memory into a sticky error.
module cache_mem_arbiter
    import cache_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ireq,
    input  logic [31:0] i_iaddr,
    input  logic        i_ihit,
    output logic        o_istall,
    output logic        o_ifill_wen,
    output logic [31:0] o_ifill_addr,
    output logic [31:0] o_ifill_data,
    input  logic        i_dreq,
    input  logic        i_dwe,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dwdata,
    input  logic        i_dhit,
    output logic        o_dstall,
    output logic        o_dfill_wen,
    output logic [31:0] o_dfill_addr,
    output logic [31:0] o_dfill_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err,
    output logic        o_busy
);

    arb_state_t  state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] fill_data;
    logic        waiting;
    logic        tmr_expired;
    logic        tmr_expiring;

    assign waiting = (state == IRD) || (state == DRD) || (state == DWR);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE),
        .en       (waiting && !i_mem_ack),
        .expired  (tmr_expired),
        .expiring (tmr_expiring)
    );

    // A timeout completes the transaction as if acked, but with substitute data
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            fill_data   <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_ifill_wen <= 1'b0;
            o_dfill_wen <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_ifill_wen <= 1'b0;
            o_dfill_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_dreq && i_dwe) begin
                        state     <= DWR;
                        lat_addr  <= i_daddr;
                        lat_wdata <= i_dwdata;
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b1;
                    end else if (i_dreq && !i_dhit) begin
                        state     <= DRD;
                        lat_addr  <= i_daddr;
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b0;
                    end else if (i_ireq && !i_ihit) begin
                        state     <= IRD;
                        lat_addr  <= i_iaddr;
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b0;
                    end
                end
                IRD, DRD, DWR: begin
                    if (i_mem_ack || tmr_expired) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        fill_data <= i_mem_ack ? i_mem_rdata : ERR_DATA;
                        if (!i_mem_ack) begin
                            o_err <= 1'b1;
                        end
                        case (state)
                            IRD: begin
                                state       <= IFILL;
                                o_ifill_wen <= 1'b1;
                            end
                            DRD: begin
                                state       <= DFILL;
                                o_dfill_wen <= 1'b1;
                            end
                            default: state <= DDONE;
                        endcase
                    end else if (tmr_expiring) begin
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_mem_addr   = lat_addr;
    assign o_mem_wdata  = lat_wdata;
    assign o_ifill_addr = lat_addr;
    assign o_ifill_data = fill_data;
    assign o_dfill_addr = lat_addr;
    assign o_dfill_data = fill_data;
    assign o_busy       = (state != IDLE);

    assign o_istall = i_ireq && (!i_ihit || (state == IFILL));
    assign o_dstall = i_dreq && ((!i_dwe && !i_dhit) || (i_dwe && (state != DDONE)) || (state == DFILL));

endmodule
